// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Register-file writeback arbiter between an execution unit (EXU)
//            and a load/store unit (LSU). It accepts at most one writeback
//            per cycle and registers it onto the register-file write port.
//            A load scoreboard blocks issue of instructions that read or
//            overwrite a register still waiting for its load data.
// Ports    : clk, rst (asynchronous, active-high)
//            wbarb_i_exu_*   EXU writeback request / wbarb_o_exu_ready grant
//            wbarb_i_lsu_*   LSU load-return request / wbarb_o_lsu_ready grant
//            wbarb_i_issue_* decoder instruction being presented
//            wbarb_o_issue_stall hazard indication to the decoder
//            wbarb_o_rd_*    registered register-file write port
// Config   : define WBARB_STARVE_GUARD_EN to enable the EXU starvation guard.
//            When it is not defined, the LSU always has priority.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbarb_i_exu_valid,
  input  logic [4:0]  wbarb_i_exu_rd_addr,
  input  logic [31:0] wbarb_i_exu_rd_data,
  output logic        wbarb_o_exu_ready,
  input  logic        wbarb_i_lsu_valid,
  input  logic [4:0]  wbarb_i_lsu_rd_addr,
  input  logic [31:0] wbarb_i_lsu_rd_data,
  output logic        wbarb_o_lsu_ready,
  input  logic        wbarb_i_issue_valid,
  input  logic        wbarb_i_issue_is_load,
  input  logic [4:0]  wbarb_i_issue_rd_addr,
  input  logic [4:0]  wbarb_i_issue_rs1_addr,
  input  logic [4:0]  wbarb_i_issue_rs2_addr,
  output logic        wbarb_o_issue_stall,
  output logic        wbarb_o_rd_wen,
  output logic [4:0]  wbarb_o_rd_addr,
  output logic [31:0] wbarb_o_rd_data
);

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  logic        force_exu;
  logic        lsu_accept;
  logic        exu_accept;
  logic        out_from_lsu;
  logic [31:0] pending;
  logic [31:0] pending_set;
  logic [31:0] pending_clr;
  logic [31:0] pending_nxt;
  logic        load_issue;

`ifdef WBARB_STARVE_GUARD_EN
  // Counts consecutive cycles in which the EXU asked but was refused.
  // Once it reaches the limit, the EXU is granted, which clears the count,
  // so the counter never runs past the limit.
  logic [3:0] starve_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (wbarb_i_exu_valid && wbarb_o_exu_ready) begin
      starve_cnt <= 4'd0;
    end else if (wbarb_i_exu_valid) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign force_exu = (starve_cnt == STARVE_LIMIT);
`else
  // Strict LSU priority: the limit has no effect in this build.
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign force_exu           = 1'b0;
`endif

  // Ready is an availability signal, not a grant: it stays high whenever the
  // competing source is idle.
  assign wbarb_o_lsu_ready = !(wbarb_i_exu_valid && force_exu);
  assign wbarb_o_exu_ready = !wbarb_i_lsu_valid || force_exu;

  assign lsu_accept = wbarb_i_lsu_valid && wbarb_o_lsu_ready;
  assign exu_accept = wbarb_i_exu_valid && wbarb_o_exu_ready && !lsu_accept;

  // Registered writeback port. Writes to x0 are accepted but never enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbarb_o_rd_wen  <= 1'b0;
      wbarb_o_rd_addr <= 5'd0;
      wbarb_o_rd_data <= 32'd0;
      out_from_lsu    <= 1'b0;
    end else if (lsu_accept) begin
      wbarb_o_rd_wen  <= (wbarb_i_lsu_rd_addr != 5'd0);
      wbarb_o_rd_addr <= wbarb_i_lsu_rd_addr;
      wbarb_o_rd_data <= wbarb_i_lsu_rd_data;
      out_from_lsu    <= 1'b1;
    end else if (exu_accept) begin
      wbarb_o_rd_wen  <= (wbarb_i_exu_rd_addr != 5'd0);
      wbarb_o_rd_addr <= wbarb_i_exu_rd_addr;
      wbarb_o_rd_data <= wbarb_i_exu_rd_data;
      out_from_lsu    <= 1'b0;
    end else begin
      wbarb_o_rd_wen  <= 1'b0;
      out_from_lsu    <= 1'b0;
    end
  end

  // Scoreboard bit 0 is never set, so indexing with a zero source address
  // can never report a hazard.
  assign wbarb_o_issue_stall = wbarb_i_issue_valid &&
                               (pending[wbarb_i_issue_rs1_addr] ||
                                pending[wbarb_i_issue_rs2_addr] ||
                                pending[wbarb_i_issue_rd_addr]);

  assign load_issue = wbarb_i_issue_valid && wbarb_i_issue_is_load &&
                      !wbarb_o_issue_stall && (wbarb_i_issue_rd_addr != 5'd0);

  // The clear follows the register-file write of the load data; a new load to
  // the same register on that same edge must win, so set is applied last.
  always_comb begin
    pending_set = 32'd0;
    pending_clr = 32'd0;
    if (load_issue) begin
      pending_set[wbarb_i_issue_rd_addr] = 1'b1;
    end
    if (wbarb_o_rd_wen && out_from_lsu) begin
      pending_clr[wbarb_o_rd_addr] = 1'b1;
    end
    pending_nxt    = (pending & ~pending_clr) | pending_set;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 32'd0;
    end else begin
      pending <= pending_nxt;
    end
  end

endmodule
`default_nettype wire
